// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS image-datapath inter-stage registers.
//   - Per-stage control-field layouts (ID/EX, EX/MEM) and their widths.
//   - CTRL_BUBBLE: control value carried by a bubble (all control deasserted).
//   - Default widths for pipe_stage_reg.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

  // ALU operation encoding as produced by the main decoder.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // Control bundle travelling from ID into EX.
  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_control;
  } idex_ctrl_t;

  localparam int IDEX_CTRL_W = $bits(idex_ctrl_t);

  // Control bundle travelling from EX into MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } exmem_ctrl_t;

  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);

  // Bubbles must never write registers or memory: every control bit low.
  localparam logic [63:0] CTRL_BUBBLE = '0;

  localparam int DEFAULT_CTRL_W = IDEX_CTRL_W;
  localparam int DEFAULT_DATA_W = 96;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry elastic buffer (main + skid) with a registered ready. The main
// entry drives the downstream side; the skid entry catches an input accepted
// while the output is stalled and refills main on the next output transfer.
// Ports:
//   clk, rst         clock, async active-high reset
//   flush_i          synchronous kill of both entries
//   in_valid_i/in_ready_o/in_ctrl_i/in_data_i     upstream handshake + payload
//   out_valid_o/out_ready_i/out_ctrl_o/out_data_o downstream handshake + payload
//   occ_o            entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
  parameter int                CTRL_W = 8,
  parameter int                DATA_W = 96,
  parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q;
  logic [1:0]        occ_q;
  logic              push, pop;

  assign push = in_valid_i && in_ready_q;
  assign pop  = main_vld_q && out_ready_i;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Data fields keep their last value; only validity and control die.
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_ctrl_d = BUBBLE;
    end else if (pop) begin
      if (skid_vld_q) begin
        // Skid is older than anything arriving now, so it moves up first.
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        if (push) begin
          skid_ctrl_d = in_ctrl_i;
          skid_data_d = in_data_i;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (push) begin
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;
      end else begin
        main_vld_d  = 1'b0;
        main_ctrl_d = BUBBLE;
      end
    end else if (push) begin
      if (main_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = in_ctrl_i;
        skid_data_d = in_data_i;
      end else begin
        main_vld_d  = 1'b1;
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= BUBBLE;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      // Ready is computed from next state so it falls on the same edge the
      // skid fills; no third entry is ever needed.
      in_ready_q  <= !skid_vld_d;
      occ_q       <= {main_vld_d & skid_vld_d, main_vld_d ^ skid_vld_d};
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_vld_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic elastic inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries
// a control and a data field under valid/ready, inserts zero-control bubbles on
// FLUSH and counts downstream bubble cycles.
// Build option: define SKID_EN for a two-entry skid buffer with registered
// in_ready; otherwise a single entry with combinational in_ready.
// Ports:
//   clk, CLR (async active-high reset), FLUSH (sync kill)
//   in_valid/in_ready/in_ctrl/in_data     upstream side
//   out_valid/out_ready/out_ctrl/out_data downstream side
//   occupancy   entries held
//   bubble_cnt  saturating count of out_ready && !out_valid cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

`ifdef SKID_EN

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk         (clk),
    .rst         (CLR),
    .flush_i     (FLUSH),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occ_o       (occupancy)
  );

`else

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Free slot, or the held entry leaves this cycle.
  assign in_ready = !vld_q || out_ready;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (FLUSH) begin
      vld_d  = 1'b0;
      ctrl_d = BUBBLE;
    end else if (in_valid && in_ready) begin
      vld_d  = 1'b1;
      ctrl_d = in_ctrl;
      data_d = in_data;
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
      ctrl_d = BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      vld_q  <= 1'b0;
      ctrl_q <= BUBBLE;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign occupancy = {1'b0, vld_q};

`endif

  // Bubble statistics: cleared only by CLR, FLUSH has no effect on it.
  logic [CNT_W-1:0] bub_q, bub_d;

  always_comb begin
    bub_d = bub_q;
    if (out_ready && !out_valid && (bub_q != {CNT_W{1'b1}}))
      bub_d = bub_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) bub_q <= '0;
    else     bub_q <= bub_d;
  end

  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg with a queue-based reference model and a
// per-cycle compare thread. Works with or without SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = 2;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              CLR, FLUSH, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .CLR(CLR), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  // ---------------- reference model: an in-order queue of capacity CAP ------
  ent_t              mq[$];
  logic [DATA_W-1:0] m_last;
  int                m_cnt;
  logic              m_v, m_r;
  ent_t              m_e;

  function automatic logic m_rdy();
    if (SKID) return mq.size() < CAP;
    return (mq.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge CLR) begin
    if (CLR) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      m_v = mq.size() != 0;
      m_r = m_rdy();
      if (out_ready && !m_v && m_cnt < CNT_MAX) m_cnt++;
      if (FLUSH) mq.delete();
      else begin
        if (m_v && out_ready) void'(mq.pop_front());
        if (in_valid && m_r) begin
          m_e.c = in_ctrl;
          m_e.d = in_data;
          mq.push_back(m_e);
        end
      end
      if (mq.size() != 0) m_last = mq[0].d;
    end
  end

  // ---------------- helpers ------------------------------------------------
  logic [DATA_W-1:0] rx[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_seq(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int guard;
      in_valid = 1'b1;
      in_ctrl  = CTRL_W'(32'hC0 + k);
      in_data  = DATA_W'(base + k);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      chk("push_timeout", 128'(acc), 128'(1));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    CLR = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    // Per-cycle compare against the model, plus capture of output transfers.
    fork
      forever begin
        @(negedge clk);
        chk("out_valid",  128'(out_valid),  128'(mq.size() != 0));
        chk("out_ctrl",   128'(out_ctrl),   (mq.size() != 0) ? 128'(mq[0].c) : 128'(0));
        chk("out_data",   128'(out_data),   (mq.size() != 0) ? 128'(mq[0].d) : 128'(m_last));
        chk("occupancy",  128'(occupancy),  128'(mq.size()));
        chk("in_ready",   128'(in_ready),   128'(m_rdy()));
        chk("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
        if (out_valid && out_ready && !CLR) rx.push_back(out_data);
      end
    join_none

    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_occ",       128'(occupancy), 128'(0));
    chk("rst_bubble",    128'(bubble_cnt), 128'(0));

    // ---- reset mid-stream
    CLR = 1'b0; in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 96'hA5;
    @(posedge clk); #1;
    chk("t1_acc_valid", 128'(out_valid), 128'(1));
    chk("t1_acc_data",  128'(out_data),  128'hA5);
    #2 CLR = 1'b1;
    #1;
    chk("t1_clr_valid", 128'(out_valid), 128'(0));
    chk("t1_clr_ctrl",  128'(out_ctrl),  128'(0));
    chk("t1_clr_data",  128'(out_data),  128'(0));
    chk("t1_clr_occ",   128'(occupancy), 128'(0));
    chk("t1_clr_rdy",   128'(in_ready),  128'(1));
    @(posedge clk); #1;
    CLR = 1'b0;
    @(posedge clk); #1;
    chk("t1_rel_valid", 128'(out_valid), 128'(1));
    chk("t1_rel_data",  128'(out_data),  128'hA5);
    chk("t1_rel_ctrl",  128'(out_ctrl),  128'h3C);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // ---- streaming, counter cleared first so the bubble count is exact
    CLR = 1'b1;
    @(posedge clk); #1;
    CLR = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = CTRL_W'(32'h10 + i); in_data = DATA_W'(i);
      @(posedge clk); #1;
      chk("stream_data", 128'(out_data),  128'(i));
      chk("stream_occ",  128'(occupancy), 128'(1));
    end
    in_valid = 1'b0;
    chk("stream_bubble", 128'(bubble_cnt), 128'(1));
    repeat (2) @(posedge clk); #1;

    // ---- back-pressure, 3 stalled cycles
    rx.delete();
    fork
      push_seq(3, 'h11);
      begin
        out_ready = 1'b0;
        @(posedge clk); #2;
        chk("bp_occ1", 128'(occupancy), 128'(1));
        chk("bp_rdy1", 128'(in_ready),  128'(SKID ? 1 : 0));
        @(posedge clk); #2;
        chk("bp_occ2", 128'(occupancy), 128'(SKID ? 2 : 1));
        chk("bp_rdy2", 128'(in_ready),  128'(0));
        @(posedge clk); #2;
        chk("bp_occ3", 128'(occupancy), 128'(SKID ? 2 : 1));
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_rx_cnt", 128'(rx.size()), 128'(3));
    chk("bp_rx0", 128'(rx[0]), 128'h11);
    chk("bp_rx1", 128'(rx[1]), 128'h12);
    chk("bp_rx2", 128'(rx[2]), 128'h13);

    // ---- flush with a simultaneous input
    rx.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 96'h21;
    @(posedge clk); #1;
    in_ctrl = 8'hA2; in_data = 96'h22;
    @(posedge clk); #1;
    chk("fl_pre_occ", 128'(occupancy), 128'(SKID ? 2 : 1));
    FLUSH = 1'b1; in_ctrl = 8'hFF; in_data = 96'h55;
    @(posedge clk); #1;
    FLUSH = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl",  128'(out_ctrl),  128'(0));
    chk("fl_occ",   128'(occupancy), 128'(0));
    chk("fl_data",  128'(out_data),  128'h21);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("fl_rx_none", 128'(rx.size()), 128'(0));

    // ---- bubble counter saturation
    CLR = 1'b1;
    @(posedge clk); #1;
    CLR = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("bub_10", 128'(bubble_cnt), 128'(10));
    repeat (10) @(posedge clk); #1;
    chk("bub_sat", 128'(bubble_cnt), 128'(15));
    #2 CLR = 1'b1;
    #1;
    chk("bub_clr", 128'(bubble_cnt), 128'(0));
    @(posedge clk); #1;
    CLR = 1'b0;
    repeat (2) @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
